// File: rtl/dev_bridge_if.sv
// dev_bridge_if: CPU memory-mapped data port as seen by dev_bridge.
//
// Handshake: cpu_req_i is the request valid. The CPU raises it with
// cpu_we_i/cpu_addr_i/cpu_wdata_i stable and holds all four until it sees
// cpu_ack_o=1 for one cycle. cpu_ack_o is the single-cycle completion (the
// "ready" side); cpu_rdata_o and cpu_err_o are meaningful only in that cycle
// and are 0 otherwise. The request is accepted on the first rising edge that
// finds the bridge idle with cpu_req_i=1; a request left high after the ack
// starts the next transaction.
//
// Signals:
//   cpu_req_i    request valid
//   cpu_we_i     1 = store, 0 = load
//   cpu_addr_i   byte address
//   cpu_wdata_i  store data
//   cpu_rdata_o  load data (valid with ack)
//   cpu_ack_o    one-cycle completion pulse
//   cpu_err_o    decode error (valid with ack)
interface dev_bridge_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ack_o;
  logic        cpu_err_o;

  // CPU side
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ack_o, cpu_err_o
  );

  // Bridge side
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ack_o, cpu_err_o
  );
endinterface

// File: rtl/dev_bridge.sv
// dev_bridge: sequential bridge from the CPU data port to two timer/counter
// devices (TC0 at BASE0, TC1 at BASE1). One CPU access at a time is decoded
// to a device and word offset, presented to the device bus for exactly one
// cycle, and acknowledged the following cycle. Device interrupt lines are
// registered once into the CPU hardware-interrupt vector.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   cpu                  CPU data port (dev_bridge_if.slave)
//   dev_add_o            word offset to both devices (valid in ACCESS)
//   dev_dat_o            write data to both devices (valid in ACCESS)
//   dev0_we_o/dev1_we_o  per-device write strobe (ACCESS, stores only)
//   dev0_dat_i/dev1_dat_i device read data, combinational from dev_add_o
//   dev0_irq_i/dev1_irq_i device interrupt requests
//   hwint_o              CPU interrupt vector: [1:0] = irq delayed 1 cycle
//   dbg_state_o          FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module dev_bridge #(
  parameter logic [31:0] BASE0  = 32'h0000_7F00,
  parameter logic [31:0] BASE1  = 32'h0000_7F10,
  parameter int          DEV_AW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dev_bridge_if.slave       cpu,
  output logic [DEV_AW:1]   dev_add_o,
  output logic [31:0]       dev_dat_o,
  output logic              dev0_we_o,
  output logic              dev1_we_o,
  input  logic [31:0]       dev0_dat_i,
  input  logic [31:0]       dev1_dat_i,
  input  logic              dev0_irq_i,
  input  logic              dev1_irq_i,
  output logic [5:0]        hwint_o,
  output logic [1:0]        dbg_state_o
);

  localparam int HI = DEV_AW + 2;
  // Word indices 0..2 are CTRL, PRESET, COUNT; anything at or above is a miss.
  localparam logic [DEV_AW-1:0] IDX_LIMIT = DEV_AW'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   sel1_q;   // access targets TC1 (else TC0)
  logic   we_q;     // access is a store

  logic [DEV_AW-1:0] word_idx;
  logic              aligned;
  logic              idx_ok;
  logic              hit0;
  logic              hit1;

  assign word_idx = cpu.cpu_addr_i[DEV_AW+1:2];
  assign aligned  = (cpu.cpu_addr_i[1:0] == 2'b00);
  assign idx_ok   = (word_idx < IDX_LIMIT);
  assign hit0     = (cpu.cpu_addr_i[31:HI] == BASE0[31:HI]) && aligned && idx_ok;
  assign hit1     = (cpu.cpu_addr_i[31:HI] == BASE1[31:HI]) && aligned && idx_ok;

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      sel1_q          <= 1'b0;
      we_q            <= 1'b0;
      cpu.cpu_ack_o   <= 1'b0;
      cpu.cpu_err_o   <= 1'b0;
      cpu.cpu_rdata_o <= 32'h0;
      dev_add_o       <= '0;
      dev_dat_o       <= 32'h0;
      dev0_we_o       <= 1'b0;
      dev1_we_o       <= 1'b0;
      hwint_o         <= 6'h0;
    end else begin
      // Interrupts pass straight through one register; no latching.
      hwint_o <= {4'b0000, dev1_irq_i, dev0_irq_i};

      // Every bus output is a one-cycle pulse; default them low and let the
      // state that owns them raise them for the following cycle.
      cpu.cpu_ack_o   <= 1'b0;
      cpu.cpu_err_o   <= 1'b0;
      cpu.cpu_rdata_o <= 32'h0;
      dev_add_o       <= '0;
      dev_dat_o       <= 32'h0;
      dev0_we_o       <= 1'b0;
      dev1_we_o       <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu.cpu_req_i) begin
            if (hit0 || hit1) begin
              state     <= ACCESS;
              sel1_q    <= hit1;
              we_q      <= cpu.cpu_we_i;
              dev_add_o <= word_idx;
              dev_dat_o <= cpu.cpu_wdata_i;
              dev0_we_o <= cpu.cpu_we_i & hit0;
              dev1_we_o <= cpu.cpu_we_i & hit1;
            end else begin
              // Decode miss skips the device bus entirely.
              state         <= RESP;
              cpu.cpu_ack_o <= 1'b1;
              cpu.cpu_err_o <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Load data is the device value at the edge that ends ACCESS,
          // the same edge at which a store lands in the device.
          state         <= RESP;
          cpu.cpu_ack_o <= 1'b1;
          if (!we_q) begin
            cpu.cpu_rdata_o <= sel1_q ? dev1_dat_i : dev0_dat_i;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dev_bridge.sv
module tb_dev_bridge;

  localparam logic [31:0] BASE0 = 32'h0000_7F00;
  localparam logic [31:0] BASE1 = 32'h0000_7F10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dev_bridge_if bus();
  logic [2:1]  dev_add;
  logic [31:0] dev_dat, dev0_dat, dev1_dat;
  logic        dev0_we, dev1_we, dev0_irq, dev1_irq;
  logic [5:0]  hwint;
  logic [1:0]  dbg_state;

  dev_bridge #(.BASE0(BASE0), .BASE1(BASE1), .DEV_AW(2)) dut (
    .clk_i(clk), .rst_i(rst), .cpu(bus),
    .dev_add_o(dev_add), .dev_dat_o(dev_dat),
    .dev0_we_o(dev0_we), .dev1_we_o(dev1_we),
    .dev0_dat_i(dev0_dat), .dev1_dat_i(dev1_dat),
    .dev0_irq_i(dev0_irq), .dev1_irq_i(dev1_irq),
    .hwint_o(hwint), .dbg_state_o(dbg_state)
  );

  // ---------------- timer/counter device stand-ins ----------------
  // CTRL bit0 = enable, bit3 = interrupt mask; PRESET write loads COUNT;
  // COUNT counts down to 0 while enabled; irq = EN & IM & (COUNT == 0).
  logic [31:0] tc_ctrl [2];
  logic [31:0] tc_preset [2];
  logic [31:0] tc_count [2];
  logic [1:0]  force_irq;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if ((k == 0) ? dev0_we : dev1_we) begin
        case (dev_add)
          2'd0: tc_ctrl[k] <= dev_dat;
          2'd1: begin tc_preset[k] <= dev_dat; tc_count[k] <= dev_dat; end
          default: ;
        endcase
      end else if (tc_ctrl[k][0] && tc_count[k] != 0) begin
        tc_count[k] <= tc_count[k] - 1;
      end
    end
  end

  always_comb begin
    dev0_dat = 32'h0;
    dev1_dat = 32'h0;
    case (dev_add)
      2'd0: begin dev0_dat = tc_ctrl[0];   dev1_dat = tc_ctrl[1];   end
      2'd1: begin dev0_dat = tc_preset[0]; dev1_dat = tc_preset[1]; end
      2'd2: begin dev0_dat = tc_count[0];  dev1_dat = tc_count[1];  end
      default: ;
    endcase
  end

  assign dev0_irq = (tc_ctrl[0][0] & tc_ctrl[0][3] & (tc_count[0] == 0)) | force_irq[0];
  assign dev1_irq = (tc_ctrl[1][0] & tc_ctrl[1][3] & (tc_count[1] == 0)) | force_irq[1];

  // Interrupt expectation: the vector shows the irq lines of one edge ago.
  logic [1:0] irq_d;
  always @(posedge clk) irq_d <= rst ? 2'b00 : {dev1_irq, dev0_irq};

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_reg [2][3];   // [device][CTRL, PRESET, COUNT]
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver ----------------
  // Called #1 after a rising edge. Returns what the bus showed; latency is
  // counted in cycles from the edge that samples the request.
  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit release_req,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int n0, output int n1, output logic [1:0] add_w,
                           output logic [31:0] dat_w, output bit bad, output bit to);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    rd = 32'h0; er = 1'b0; lat = -1; n0 = 0; n1 = 0;
    add_w = 2'd0; dat_w = 32'h0; bad = 1'b0; to = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (dev0_we) begin n0++; add_w = dev_add; dat_w = dev_dat; end
      if (dev1_we) begin n1++; add_w = dev_add; dat_w = dev_dat; end
      if (bus.cpu_ack_o) begin
        rd = bus.cpu_rdata_o; er = bus.cpu_err_o; lat = n - 1; to = 1'b0;
        if (dev0_we || dev1_we || dev_add != 0 || dev_dat != 0) bad = 1'b1;
        break;
      end else if (bus.cpu_err_o || bus.cpu_rdata_o != 0) begin
        bad = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (release_req) bus.cpu_req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; force_irq = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack_o, bus.cpu_err_o, bus.cpu_rdata_o, dev_add, dev_dat, dev0_we, dev1_we, hwint, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b err=%b rdata=%h add=%h dat=%h we=%b%b hwint=%b state=%0d required all 0",
               bus.cpu_ack_o, bus.cpu_err_o, bus.cpu_rdata_o, dev_add, dev_dat, dev1_we, dev0_we, hwint, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (hwint !== 6'b000011) begin errors++; $display("FAIL reset_hwint_after got=%b exp=000011", hwint); end
    @(posedge clk); #1;
    force_irq = 2'b00;
  endtask

  task automatic test_tc0_preset();
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    drive_txn(1'b1, 32'h7F04, 32'h89AB_CDEF, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL st0_latency got=%0d exp=2", lat); end
    checks++; if (er !== 1'b0)    begin errors++; $display("FAIL st0_err got=%b exp=0", er); end
    checks++; if (n0 != 1 || n1 != 0) begin errors++; $display("FAIL st0_we_pulses got=%0d/%0d exp=1/0", n0, n1); end
    checks++; if (aw !== 2'd1 || dw !== 32'h89AB_CDEF) begin errors++; $display("FAIL st0_bus got add=%0d dat=%h exp add=1 dat=89abcdef", aw, dw); end
    checks++; if (bad) begin errors++; $display("FAIL st0_quiet got=1 exp=0"); end
    ref_reg[0][1] = 32'h89AB_CDEF; ref_reg[0][2] = 32'h89AB_CDEF;
    drive_txn(1'b0, 32'h7F04, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL ld0_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h89AB_CDEF) begin errors++; $display("FAIL ld0_rdata got=%h exp=89abcdef", rd); end
    checks++; if (n0 != 0 || n1 != 0) begin errors++; $display("FAIL ld0_we_pulses got=%0d/%0d exp=0/0", n0, n1); end
  endtask

  task automatic test_tc1_isolation();
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    drive_txn(1'b1, 32'h7F14, 32'h3, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || n0 != 0 || n1 != 1) begin errors++; $display("FAIL st1_we_pulses got=%0d/%0d exp=0/1", n0, n1); end
    ref_reg[1][1] = 32'h3; ref_reg[1][2] = 32'h3;
    drive_txn(1'b0, 32'h7F04, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (rd !== ref_reg[0][1]) begin errors++; $display("FAIL iso_tc0_preset got=%h exp=%h", rd, ref_reg[0][1]); end
    drive_txn(1'b0, 32'h7F14, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL iso_tc1_preset got=%h exp=3", rd); end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [4] = '{32'h7F0C, 32'h7F02, 32'h7F20, 32'h0001_7F04};
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    for (int i = 0; i < 4; i++) begin
      drive_txn(i == 3, addrs[i], 32'hFFFF_FFFF, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
      checks++;
      if (to || lat != 1 || er !== 1'b1 || rd !== 32'h0 || n0 != 0 || n1 != 0 || bad) begin
        errors++;
        $display("FAIL miss_%h got lat=%0d err=%b rdata=%h we=%0d/%0d exp lat=1 err=1 rdata=0 we=0/0",
                 addrs[i], lat, er, rd, n0, n1);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, dw, addr, wdata, base, exp; logic er, we; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    int k, idx, off; bit hit;
    for (int t = 0; t < 40; t++) begin
      k   = $urandom_range(0, 2);
      idx = $urandom_range(0, 3);
      off = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      if (k == 0)      base = BASE0;
      else if (k == 1) base = BASE1;
      else             base = ($urandom_range(0, 1) == 1) ? 32'h0001_7F00 : 32'h0000_7F20;
      addr  = base + 32'(idx * 4 + off);
      hit   = (k < 2) && (idx < 3) && (off == 0);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (idx == 0) wdata[0] = 1'b0;   // keep counters stopped
      exp_q.push_back((hit && !we) ? ref_reg[k][idx] : 32'h0);
      drive_txn(we, addr, wdata, 1'($urandom_range(0, 1)), rd, er, lat, n0, n1, aw, dw, bad, to);
      exp = exp_q.pop_front();
      checks++; if (to || lat != (hit ? 2 : 1)) begin errors++; $display("FAIL rnd%0d_latency addr=%h got=%0d exp=%0d", t, addr, lat, hit ? 2 : 1); end
      checks++; if (er !== !hit) begin errors++; $display("FAIL rnd%0d_err addr=%h got=%b exp=%b", t, addr, er, !hit); end
      checks++; if (rd !== exp) begin errors++; $display("FAIL rnd%0d_rdata addr=%h got=%h exp=%h", t, addr, rd, exp); end
      checks++;
      if (n0 != ((hit && we && k == 0) ? 1 : 0) || n1 != ((hit && we && k == 1) ? 1 : 0) || bad) begin
        errors++; $display("FAIL rnd%0d_strobes addr=%h we=%b got=%0d/%0d bad=%b", t, addr, we, n0, n1, bad);
      end
      if (hit && we && idx == 0) ref_reg[k][0] = wdata;
      if (hit && we && idx == 1) begin ref_reg[k][1] = wdata; ref_reg[k][2] = wdata; end
    end
    bus.cpu_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    drive_txn(1'b0, 32'h7F04, 32'h0, 1'b0, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 2 || rd !== ref_reg[0][1]) begin errors++; $display("FAIL b2b_hit1 got lat=%0d rdata=%h exp lat=2 rdata=%h", lat, rd, ref_reg[0][1]); end
    drive_txn(1'b0, 32'h7F0C, 32'h0, 1'b0, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 1 || er !== 1'b1) begin errors++; $display("FAIL b2b_miss got lat=%0d err=%b exp lat=1 err=1", lat, er); end
    drive_txn(1'b0, 32'h7F14, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 2 || rd !== ref_reg[1][1]) begin errors++; $display("FAIL b2b_hit2 got lat=%0d rdata=%h exp lat=2 rdata=%h", lat, rd, ref_reg[1][1]); end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    bit rose = 1'b0;
    drive_txn(1'b1, 32'h7F04, 32'h3, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    drive_txn(1'b1, 32'h7F00, 32'h9, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (hwint !== {4'b0000, irq_d}) begin errors++; $display("FAIL irq_lag_on cyc=%0d got=%b exp=%b", c, hwint, {4'b0000, irq_d}); end
      if (hwint[0]) rose = 1'b1;
    end
    checks++; if (!rose) begin errors++; $display("FAIL irq_rise got=0 exp=1"); end
    @(posedge clk); #1;
    drive_txn(1'b1, 32'h7F00, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (hwint !== {4'b0000, irq_d} || hwint[0] !== 1'b0) begin errors++; $display("FAIL irq_lag_off cyc=%0d got=%b exp=%b", c, hwint, 6'b0); end
    end
    @(posedge clk); #1;
    ref_reg[0][0] = 32'h0; ref_reg[0][1] = 32'h3; ref_reg[0][2] = 32'h0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, dw; logic er; int lat, n0, n1; logic [1:0] aw; bit bad, to;
    bit acked = 1'b0;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h7F04; bus.cpu_wdata_i = 32'h0;
    @(negedge clk);           // IDLE, request sampled at next edge
    @(negedge clk);           // ACCESS
    rst = 1'b1; bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_ack_o) acked = 1'b1;
    end
    checks++; if (acked) begin errors++; $display("FAIL rstmid_no_ack got=1 exp=0"); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    @(posedge clk); #1;
    drive_txn(1'b0, 32'h7F08, 32'h0, 1'b1, rd, er, lat, n0, n1, aw, dw, bad, to);
    checks++; if (to || lat != 2 || er !== 1'b0) begin errors++; $display("FAIL rstmid_fresh_latency got=%0d err=%b exp=2 err=0", lat, er); end
    checks++; if (rd !== ref_reg[0][2]) begin errors++; $display("FAIL rstmid_fresh_rdata got=%h exp=%h", rd, ref_reg[0][2]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      tc_ctrl[k] = 32'h0; tc_preset[k] = 32'h0; tc_count[k] = 32'h0;
      for (int r = 0; r < 3; r++) ref_reg[k][r] = 32'h0;
    end
    force_irq = 2'b00;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0; bus.cpu_wdata_i = 32'h0;
    test_reset();
    test_tc0_preset();
    test_tc1_isolation();
    test_decode_err();
    test_random();
    test_back_to_back();
    test_interrupt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
